// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: latches a WIDTH-bit pattern on start and shifts it out
// MSB-first, holding each bit for TICK_DIV clocks. Optional looping replays
// the latched pattern back-to-back; the line rests at IDLE_LEVEL otherwise.
module serial_bit_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             loop,
  input  logic [WIDTH-1:0] data_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(TICK_DIV) + 1;
  localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic period_end;
  logic last_bit;

  assign period_end = (tick_q == TICK_LAST);
  assign last_bit   = (bit_cnt_q == BIT_LAST);

  // State and registered outputs, async reset to idle values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pattern_q    <= '0;
      shift_q      <= '0;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= IDLE_LEVEL;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      shift_q      <= shift_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (period_end && last_bit && !loop) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output values for the next cycle
  always_comb begin
    pattern_d    = pattern_q;
    shift_d      = shift_q;
    tick_d       = tick_q;
    bit_cnt_d    = bit_cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_out_d = IDLE_LEVEL;
        busy_d    = 1'b0;
        if (start) begin
          pattern_d   = data_in;
          shift_d     = data_in;
          tick_d      = '0;
          bit_cnt_d   = '0;
          bit_out_d   = data_in[WIDTH-1];
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (period_end) begin
          tick_d = '0;
          if (!last_bit) begin
            // Rotate rather than shift so every bit of the register is consumed;
            // the bits wrapped into the LSBs are never presented.
            shift_d     = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
            bit_cnt_d   = bit_cnt_q + BW'(1);
            bit_out_d   = shift_q[WIDTH-2];
            bit_valid_d = 1'b1;
          end else if (loop) begin
            shift_d      = pattern_q;
            bit_cnt_d    = '0;
            bit_out_d    = pattern_q[WIDTH-1];
            bit_valid_d  = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            bit_out_d    = IDLE_LEVEL;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_DONE: begin
        bit_out_d = IDLE_LEVEL;
        busy_d    = 1'b0;
        tick_d    = '0;
      end
      default: begin
        bit_out_d = IDLE_LEVEL;
        busy_d    = 1'b0;
        tick_d    = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: one instance with TICK_DIV=3 and one with
// TICK_DIV=1, both WIDTH=4, checked cycle by cycle against a frame-timing model.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, loop = 1'b0;
  logic [3:0] data_in = '0;
  logic       start1 = 1'b0, loop1 = 1'b0;
  logic [3:0] data_in1 = '0;
  logic       bit_out, bit_valid, busy, frame_done;
  logic       bit_out1, bit_valid1, busy1, frame_done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = clk_en ? ~clk : clk;

  serial_bit_feeder #(.WIDTH(4), .TICK_DIV(3), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .loop(loop), .data_in(data_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .frame_done(frame_done)
  );

  serial_bit_feeder #(.WIDTH(4), .TICK_DIV(1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .loop(loop1), .data_in(data_in1),
    .bit_out(bit_out1), .bit_valid(bit_valid1), .busy(busy1), .frame_done(frame_done1)
  );

  logic [3:0] obs, obs1;
  assign obs  = {bit_out, bit_valid, busy, frame_done};
  assign obs1 = {bit_out1, bit_valid1, busy1, frame_done1};

  // Expected {bit_out, bit_valid, busy, frame_done} at c cycles after the start
  // edge, for nf back-to-back frames of pattern p with bit period td.
  function automatic logic [3:0] ref_out(input logic [3:0] p, input int c,
                                         input int td, input int nf);
    int flen, total, f;
    flen  = 4 * td;
    total = nf * flen;
    if (c < total) begin
      f = c % flen;
      return {p[3 - f / td], (f % td) == 0, 1'b1, (c > 0 && f == 0)};
    end else if (c == total) begin
      return 4'b1001;
    end
    return 4'b1000;
  endfunction

  // Drive start for exactly one sampling edge; returns #1 after that edge (c=0).
  task automatic launch(input logic [3:0] p);
    @(posedge clk); #1;
    data_in = p;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_noclk got %b exp %b", obs, 4'b1000);
    end
    n_checks++;
    if (obs1 !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_noclk_td1 got %b exp %b", obs1, 4'b1000);
    end
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b exp %b", obs, 4'b1000);
    end
  endtask

  task automatic test_single_frame;
    launch(4'b1001);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (obs !== ref_out(4'b1001, c, 3, 1)) begin
        n_fail++;
        $display("FAIL single_frame c=%0d got %b exp %b", c, obs, ref_out(4'b1001, c, 3, 1));
      end
    end
  endtask

  task automatic test_ignore_midframe;
    launch(4'b1001);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (obs !== ref_out(4'b1001, c, 3, 1)) begin
        n_fail++;
        $display("FAIL ignore_midframe c=%0d got %b exp %b", c, obs, ref_out(4'b1001, c, 3, 1));
      end
      if (c == 2) begin start = 1'b1; data_in = 4'b0000; end
      if (c == 4) start = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    loop = 1'b1;
    launch(4'b0110);
    for (int c = 0; c <= 27; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (obs !== ref_out(4'b0110, c, 3, 2)) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got %b exp %b", c, obs, ref_out(4'b0110, c, 3, 2));
      end
      if (c == 15) loop = 1'b0;
    end
  endtask

  task automatic test_reset_midframe;
    launch(4'b1001);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_midframe got %b exp %b", obs, 4'b1000);
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_held got %b exp %b", obs, 4'b1000);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL after_reset_idle got %b exp %b", obs, 4'b1000);
    end
    launch(4'b1100);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (obs !== ref_out(4'b1100, c, 3, 1)) begin
        n_fail++;
        $display("FAIL post_reset_frame c=%0d got %b exp %b", c, obs, ref_out(4'b1100, c, 3, 1));
      end
    end
  endtask

  task automatic test_tick1;
    @(posedge clk); #1;
    data_in1 = 4'b0101;
    start1   = 1'b1;
    @(posedge clk); #1;
    start1   = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (obs1 !== ref_out(4'b0101, c, 1, 1)) begin
        n_fail++;
        $display("FAIL tick1 c=%0d got %b exp %b", c, obs1, ref_out(4'b0101, c, 1, 1));
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      logic [3:0] p;
      int nf;
      p  = 4'($urandom_range(0, 15));
      nf = $urandom_range(1, 3);
      loop = (nf > 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      launch(p);
      for (int c = 0; c <= nf * 12 + 2; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        n_checks++;
        if (obs !== ref_out(p, c, 3, nf)) begin
          n_fail++;
          $display("FAIL random it=%0d p=%b nf=%0d c=%0d got %b exp %b",
                   it, p, nf, c, obs, ref_out(p, c, 3, nf));
        end
        if (c == (nf - 1) * 12 + 1) loop = 1'b0;
        if (c == 4) data_in = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_tick1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
